// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and fetch constants.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two FIFO of {pc, instruction} pairs with a synchronous flush.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic                     valid_o,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_en, pop_en;

   assign push_en = push_i && (count_q != CW'(DEPTH));
   assign pop_en  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
         // Simultaneous push and pop leaves the occupancy unchanged.
         unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding request FSM feeding a prefetch buffer,
// with redirect flushing the buffer and discarding any in-flight response.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned    DW       = 32,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [DW-1:0]  RESET_PC = DW'(DEFAULT_RESET_PC)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req_o,
   output logic [DW-1:0] imem_addr_o,
   input  logic          imem_ready_i,
   input  logic          imem_rvalid_i,
   input  logic [DW-1:0] imem_rdata_i,
   input  logic          redirect_i,
   input  logic [DW-1:0] redirect_pc_i,
   output logic          instr_valid_o,
   output logic [DW-1:0] instr_o,
   output logic [DW-1:0] pc_o,
   input  logic          instr_ready_i
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [DW-1:0]     fetch_pc_q, fetch_pc_d;
   logic [DW-1:0]     req_pc_q, req_pc_d;
   logic [DW-1:0]     redirect_target;
   logic              accept, push, pop;
   logic [CW-1:0]     count;
   logic [2*DW-1:0]   head;
   logic              fifo_valid;

   assign redirect_target = {redirect_pc_i[DW-1:2], 2'b00};
   assign imem_addr_o     = fetch_pc_q;
   // Qualified by rst so no request escapes while reset is held.
   assign imem_req_o      = !rst && (state_q == ST_IDLE) && (count < CW'(DEPTH)) && !redirect_i;
   assign accept          = imem_req_o && imem_ready_i;
   assign pop             = fifo_valid && instr_ready_i && !redirect_i;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + DW'(INSTR_BYTES);
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               push    = !redirect_i;
               state_d = ST_IDLE;
            end else if (redirect_i) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (imem_rvalid_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Request issue is already blocked during redirect, so this never races an accept.
      if (redirect_i) fetch_pc_d = redirect_target;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   fetch_fifo #(
      .WIDTH (2*DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_i),
      .push_i      (push),
      .push_data_i ({req_pc_q, imem_rdata_i}),
      .pop_i       (pop),
      .valid_o     (fifo_valid),
      .head_o      (head),
      .count_o     (count)
   );

   assign instr_valid_o = fifo_valid;
   assign pc_o          = head[2*DW-1:DW];
   assign instr_o       = head[DW-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based
// model of the fetched instruction stream; the bench also plays the instruction memory.
module tb_fetch_unit;

   localparam int unsigned   DW       = 32;
   localparam int unsigned   DEPTH    = 4;
   localparam logic [31:0]   RESET_PC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req_o;
   logic [DW-1:0] imem_addr_o;
   logic          imem_ready_i;
   logic          imem_rvalid_i;
   logic [DW-1:0] imem_rdata_i;
   logic          redirect_i;
   logic [DW-1:0] redirect_pc_i;
   logic          instr_valid_o;
   logic [DW-1:0] instr_o;
   logic [DW-1:0] pc_o;
   logic          instr_ready_i;

   fetch_unit #(.DW(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ready_i  (imem_ready_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_ready_i (instr_ready_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: architectural view of the fetch stream.
   logic [63:0] m_q[$];
   logic [31:0] m_pc;
   logic [31:0] mem_addr;
   logic        m_out;
   logic        m_drop;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc   = RESET_PC;
      m_out  = 1'b0;
      m_drop = 1'b0;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input logic rd, input logic [31:0] rpc, input logic ir,
                       input logic mr, input logic rv);
      logic        exp_req;
      logic        busy;
      logic [31:0] rdata;
      check("valid", instr_valid_o, m_q.size() != 0);
      if (m_q.size() != 0) begin
         check("pc", pc_o, m_q[0][63:32]);
         check("instr", instr_o, m_q[0][31:0]);
      end
      check("addr", imem_addr_o, m_pc);
      busy          = m_out || m_drop;
      rdata         = busy ? (mem_addr ^ 32'hA5) : $urandom;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      instr_ready_i = ir;
      imem_ready_i  = mr;
      imem_rvalid_i = rv;
      imem_rdata_i  = rdata;
      #1;
      exp_req = !m_out && !m_drop && (m_q.size() < DEPTH) && !rd;
      check("req", imem_req_o, exp_req);
      if (rd) begin
         m_q.delete();
         m_pc = {rpc[31:2], 2'b00};
         if (m_out) begin
            m_out  = 1'b0;
            m_drop = !rv;
         end else if (m_drop && rv) begin
            m_drop = 1'b0;
         end
      end else begin
         if (m_q.size() != 0 && ir) void'(m_q.pop_front());
         if (m_out && rv) begin
            m_q.push_back({mem_addr, rdata});
            m_out = 1'b0;
         end else if (m_drop && rv) begin
            m_drop = 1'b0;
         end
         if (exp_req && mr) begin
            m_out    = 1'b1;
            mem_addr = m_pc;
            m_pc     = m_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic run_normal(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b1, m_out || m_drop);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
      imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_valid", instr_valid_o, 1'b0);
      check("rst_req", imem_req_o, 1'b0);
      check("rst_addr", imem_addr_o, RESET_PC);
      rst = 1'b0;

      // Full throughput from reset: memory answers one cycle after each accept.
      run_normal(12);

      // Consumer stalls: buffer fills to DEPTH and issue stops, then drains.
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b1, m_out || m_drop);
      check("full_count", m_q.size(), DEPTH);
      run_normal(10);

      // Redirect while waiting; stale response arrives two cycles later.
      for (int i = 0; i < 10 && !m_out; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("reach_wait", m_out, 1'b1);
      step(1'b1, 32'h103, 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      run_normal(8);

      // Redirect coinciding with a response and a pop while two entries are buffered.
      for (int i = 0; i < 30 && !(m_q.size() == 2 && m_out); i++)
         step(1'b0, 32'h0, 1'b0, 1'b1, m_out);
      check("reach_cnt2", (m_q.size() == 2) && m_out, 1'b1);
      step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
      run_normal(8);

      // Address wrap at the top of the address space.
      step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, m_out || m_drop);
      run_normal(10);

      // Asynchronous reset while a request is outstanding and the buffer is non-empty.
      for (int i = 0; i < 30 && !(m_q.size() != 0 && m_out); i++)
         step(1'b0, 32'h0, 1'b0, 1'b1, m_out && (m_q.size() == 0));
      check("reach_wait2", (m_q.size() != 0) && m_out, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", instr_valid_o, 1'b0);
      check("arst_req", imem_req_o, 1'b0);
      check("arst_addr", imem_addr_o, RESET_PC);
      model_reset();
      imem_rvalid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      run_normal(10);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic        rd, ir, mr, rv;
         logic [31:0] rpc;
         rd  = ($urandom % 20) == 0;
         rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         ir  = ($urandom % 4) != 0;
         mr  = ($urandom % 3) != 0;
         rv  = (m_out || m_drop) ? logic'($urandom % 2) : (($urandom % 16) == 0);
         step(rd, rpc, ir, mr, rv);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
